// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: instruction fetch unit with a small in-order queue.
// Issues one word read at a time on the ibus, queues {rdata, pc} for the
// consumer, and supports redirect (flush + restart) and halt.
// Optional feature macro: RV_FETCH_MISALIGN_FAULT_EN -- a misaligned
// redirect enqueues a single fault entry and parks the fetcher in STOP.

package rv_fetch_pkg;
  typedef enum logic [1:0] {READ = 2'b00, WRITE = 2'b01} ttype_e;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} tsize_e;
endpackage

module rv_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4
)(
  input  logic        clk,
  input  logic        rst_n,
  output logic        ibus_bstart,
  output logic        ibus_breq,
  output ttype_e      ibus_ttype,
  output tsize_e      ibus_tsize,
  output logic [31:0] ibus_addr,
  input  logic        ibus_bdone,
  input  logic [31:0] ibus_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

`ifdef RV_FETCH_MISALIGN_FAULT_EN
  typedef enum logic [2:0] {RUN, WAIT, DROP, HALTED, STOP} state_e;
`else
  typedef enum logic [1:0] {RUN, WAIT, DROP, HALTED} state_e;
`endif

  state_e          r_state, w_state_nxt, w_resume;
  logic [31:0]     r_fetch_pc, w_pc_nxt;
  logic [31:0]     r_req_addr;      // address of the outstanding transfer
  logic [31:0]     w_redir_pc;
  logic [AW-1:0]   r_wptr, r_rptr, w_waddr;
  logic [CW-1:0]   r_count;
  logic            w_bstart, w_push, w_pop;
  logic [31:0]     w_push_inst, w_push_pc;
  logic [31:0]     r_mem_inst [DEPTH];
  logic [31:0]     r_mem_pc   [DEPTH];

`ifdef RV_FETCH_MISALIGN_FAULT_EN
  logic            r_mem_fault [DEPTH];
  logic            r_fault_pend;    // STOP owed once the bus / halt clears
  logic            w_pend, w_pend_nxt, w_misalign, w_push_fault;

  assign w_misalign = redirect & (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc = redirect_pc;
  assign w_pend     = redirect ? w_misalign : r_fault_pend;
  assign w_resume   = w_pend ? STOP : RUN;
`else
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_resume   = RUN;
`endif

  assign inst_valid = (r_count != '0);
  assign w_pop      = inst_valid & inst_ready & ~redirect;
  // A flush restarts the ring at slot 0, so a same-edge fault push lands there.
  assign w_waddr    = redirect ? '0 : r_wptr;

  // Next-state, fetch address and push selection.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = redirect ? w_redir_pc : r_fetch_pc;
    w_bstart    = 1'b0;
    w_push      = 1'b0;
    w_push_inst = ibus_rdata;
    w_push_pc   = r_req_addr;
`ifdef RV_FETCH_MISALIGN_FAULT_EN
    w_push_fault = 1'b0;
`endif
    case (r_state)
      RUN: begin
        if (redirect)                     w_state_nxt = halt_req ? HALTED : w_resume;
        else if (halt_req)                w_state_nxt = HALTED;
        else if (r_count < CW'(DEPTH)) begin
          w_bstart    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_bstart = 1'b1;
        if (ibus_bdone) begin
          // Response arriving with a redirect is stale: drop it.
          if (!redirect) begin
            w_push   = 1'b1;
            w_pc_nxt = r_req_addr + 32'd4;
          end
          w_state_nxt = halt_req ? HALTED : w_resume;
        end else if (redirect) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        w_bstart = 1'b1;
        if (ibus_bdone) w_state_nxt = halt_req ? HALTED : w_resume;
      end
      HALTED: begin
        if (!halt_req) w_state_nxt = w_resume;
      end
`ifdef RV_FETCH_MISALIGN_FAULT_EN
      STOP: begin
        if (redirect && !w_misalign) w_state_nxt = halt_req ? HALTED : RUN;
      end
`endif
      default: w_state_nxt = RUN;
    endcase
`ifdef RV_FETCH_MISALIGN_FAULT_EN
    // Misaligned target replaces fetching with a single fault entry.
    if (w_misalign) begin
      w_push       = 1'b1;
      w_push_inst  = 32'h0;
      w_push_pc    = redirect_pc;
      w_push_fault = 1'b1;
    end
`endif
  end

`ifdef RV_FETCH_MISALIGN_FAULT_EN
  assign w_pend_nxt = ((w_state_nxt == HALTED) || (w_state_nxt == DROP)) ? w_pend : 1'b0;
`endif

  // FSM state, fetch PC and latched request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_fetch_pc <= INITIAL_PC;
      r_req_addr <= INITIAL_PC;
`ifdef RV_FETCH_MISALIGN_FAULT_EN
      r_fault_pend <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      if (r_state == RUN && w_bstart) r_req_addr <= r_fetch_pc;
`ifdef RV_FETCH_MISALIGN_FAULT_EN
      r_fault_pend <= w_pend_nxt;
`endif
    end
  end

  // Queue pointers and occupancy; redirect flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_rptr  <= '0;
      r_wptr  <= w_push ? AW'(1) : '0;
      r_count <= w_push ? CW'(1) : '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[w_waddr] <= w_push_inst;
      r_mem_pc[w_waddr]   <= w_push_pc;
`ifdef RV_FETCH_MISALIGN_FAULT_EN
      r_mem_fault[w_waddr] <= w_push_fault;
`endif
    end
  end

  assign inst    = r_mem_inst[r_rptr];
  assign inst_pc = r_mem_pc[r_rptr];
`ifdef RV_FETCH_MISALIGN_FAULT_EN
  assign inst_fault = inst_valid & r_mem_fault[r_rptr];
`else
  assign inst_fault = 1'b0;
`endif

  // bstart is combinational from RUN; gate so it is low while in reset.
  assign ibus_bstart = w_bstart & rst_n;
  assign ibus_breq   = ibus_bstart;
  assign ibus_ttype  = READ;
  assign ibus_tsize  = WORD;
  assign ibus_addr   = (r_state == RUN) ? r_fetch_pc : r_req_addr;
  assign halted      = (r_state == HALTED);

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue with a bus responder and a scoreboard
// of expected queue entries.
module tb_rv_fetch_queue;
  import rv_fetch_pkg::*;

  localparam logic [31:0] IPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_bstart, ibus_breq;
  ttype_e      ibus_ttype;
  tsize_e      ibus_tsize;
  logic [31:0] ibus_addr;
  logic        ibus_bdone = 1'b0;
  logic [31:0] ibus_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        halted;

  rv_fetch_queue #(.INITIAL_PC(IPC), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_bstart(ibus_bstart), .ibus_breq(ibus_breq), .ibus_ttype(ibus_ttype),
    .ibus_tsize(ibus_tsize), .ibus_addr(ibus_addr), .ibus_bdone(ibus_bdone),
    .ibus_rdata(ibus_rdata), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        sb[$];
  int          ntests = 0, nfail = 0;
  bit          tb_out = 0, tb_drop = 0, bus_en = 1;
  int          wcnt = 0, bus_lat = 0, nreq = 0, nacc = 0, n0 = 0;
  logic [31:0] tb_req_pc = 32'h0, exp_pc = IPC, hold_pc = 32'hFFFF_FFFF, last_addr = 32'h0;

  function automatic logic [31:0] data_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock: check consumer side and bus at negedge, then drive bus inputs.
  task automatic cyc();
    ent_t e;
    bit   done_now, start_now;
    @(negedge clk);
    chk("inst_valid", inst_valid, 32'(sb.size() != 0));
    if (inst_ready && !redirect && sb.size() != 0) begin
      e = sb.pop_front();
      chk("inst", inst, e.inst);
      chk("inst_pc", inst_pc, e.pc);
      chk("inst_fault", inst_fault, 32'(e.fault));
    end
    done_now  = tb_out && ibus_bdone;
    start_now = !tb_out && ibus_bstart;
    if (start_now) begin
      chk("req_addr", ibus_addr, exp_pc);
      tb_req_pc = exp_pc;
      last_addr = ibus_addr;
      nreq++;
    end
    if (redirect) begin
      sb.delete();
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef RV_FETCH_MISALIGN_FAULT_EN
      if (redirect_pc[1:0] != 2'b00) sb.push_back(ent_t'{32'h0, redirect_pc, 1'b1});
`endif
      if (tb_out && !done_now) tb_drop = 1;
    end else if (done_now && !tb_drop) begin
      sb.push_back(ent_t'{data_of(tb_req_pc), tb_req_pc, 1'b0});
      exp_pc = tb_req_pc + 32'd4;
      nacc++;
    end
    if (done_now)  begin tb_out = 0; tb_drop = 0; wcnt = 0; end
    if (start_now) begin tb_out = 1; wcnt = 0; end
    @(posedge clk); #1;
    if (tb_out) wcnt++;
    ibus_bdone = bus_en && tb_out && (wcnt > bus_lat) && (tb_req_pc != hold_pc);
    ibus_rdata = tb_out ? data_of(tb_req_pc) : 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset values
    #12;
    chk("rst_bstart", ibus_bstart, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", inst_fault, 0);
    chk("ttype", 32'(ibus_ttype), 32'(READ));
    chk("tsize", 32'(ibus_tsize), 32'(WORD));

    // sequential fetch, bus always completing, consumer always ready
    @(posedge clk); #1;
    rst_n = 1'b1; inst_ready = 1'b1;
    #1;
    chk("first_bstart", ibus_bstart, 1);
    chk("first_addr", ibus_addr, IPC);
    chk("breq", ibus_breq, 1);
    cyc(); #1;
    chk("lat_valid0", inst_valid, 0);
    cyc(); #1;
    chk("lat_valid1", inst_valid, 1);
    chk("lat_pc", inst_pc, IPC);
    repeat (8) cyc();
    chk("seq_nreq", nreq, 5);

    // fill with consumer stalled: exactly DEPTH transfers
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
    cyc(); redirect = 1'b0;
    n0 = nacc;
    repeat (20) cyc(); #1;
    chk("fill_acc", nacc - n0, 4);
    chk("fill_bstart", ibus_bstart, 0);
    chk("fill_valid", inst_valid, 1);
    n0 = nreq;
    inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
    repeat (10) cyc(); #1;
    chk("pulse_nreq", nreq - n0, 1);
    chk("pulse_bstart", ibus_bstart, 0);

    // redirect while the 0x108 transfer is outstanding
    hold_pc = 32'h108; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc(); redirect = 1'b0;
    for (int k = 0; k < 40 && !(tb_out && tb_req_pc == 32'h108); k++) cyc();
    #1;
    chk("drop_pre_addr", ibus_addr, 32'h108);
    redirect = 1'b1; redirect_pc = 32'h2000;
    cyc(); redirect = 1'b0; #1;
    chk("drop_empty", inst_valid, 0);
    chk("drop_bstart", ibus_bstart, 1);
    chk("drop_addr", ibus_addr, 32'h108);
    cyc(); hold_pc = 32'hFFFF_FFFF;
    cyc(); cyc(); #1;
    chk("post_drop_bstart", ibus_bstart, 1);
    chk("post_drop_addr", ibus_addr, 32'h2000);

    // halt raised while a transfer is outstanding
    bus_lat = 3;
    for (int k = 0; k < 20 && !tb_out; k++) cyc();
    halt_req = 1'b1;
    for (int k = 0; k < 20 && tb_out; k++) cyc();
    #1;
    chk("halt_halted", halted, 1);
    chk("halt_bstart", ibus_bstart, 0);
    n0 = nreq;
    repeat (5) cyc(); #1;
    chk("halt_nreq", nreq - n0, 0);
    chk("halt_hold", halted, 1);
    halt_req = 1'b0;
    cyc(); #1;
    chk("resume_halted", halted, 0);
    chk("resume_bstart", ibus_bstart, 1);
    chk("resume_addr", ibus_addr, tb_req_pc + 32'd4);
    bus_lat = 0;

    // misaligned redirect target
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h2002;
    n0 = nreq;
    cyc(); redirect = 1'b0; #1;
`ifdef RV_FETCH_MISALIGN_FAULT_EN
    chk("mis_valid", inst_valid, 1);
    chk("mis_fault", inst_fault, 1);
    chk("mis_pc", inst_pc, 32'h2002);
    chk("mis_inst", inst, 32'h0);
    repeat (8) cyc(); #1;
    chk("mis_nreq", nreq - n0, 0);
    chk("mis_bstart", ibus_bstart, 0);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h3000;
    n0 = nreq;
    cyc(); redirect = 1'b0;
    for (int k = 0; k < 10 && nreq == n0; k++) cyc();
    chk("mis_exit_addr", last_addr, 32'h3000);
`else
    chk("mis_fault0", inst_fault, 0);
    inst_ready = 1'b1;
    for (int k = 0; k < 10 && nreq == n0; k++) cyc();
    chk("mis_align_addr", last_addr, 32'h2000);
`endif

    // fetch address wraps past the top of memory
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); redirect = 1'b0;
    n0 = nreq;
    for (int k = 0; k < 30 && nreq < n0 + 2; k++) cyc();
    chk("wrap_addr", last_addr, 32'h0);

    // reset in the middle of a transfer
    for (int k = 0; k < 20 && !tb_out; k++) cyc();
    #2; rst_n = 1'b0; ibus_bdone = 1'b0;
    #1;
    chk("midrst_bstart", ibus_bstart, 0);
    chk("midrst_valid", inst_valid, 0);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("midrst_first_bstart", ibus_bstart, 1);
    chk("midrst_first_addr", ibus_addr, IPC);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
